tiny_rv_pipe_ctrl: RTL
======================

TINY_RV_PIPE_CTRL -- requirements
Module: tiny_rv_pipe_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: number of cycles o_pipe_flush stays high per redirect (legal range 1..7).
REQ-002 Parameter CNT_W, default 32: width of the stall performance counter.
REQ-003 i_clk  in  1  single core clock; all state updates on its rising edge.
REQ-004 i_reset  in  1  asynchronous, active-high reset.
REQ-005 i_dec_valid  in  1  decode stage holds a valid instruction.
REQ-006 i_dec_rs1, i_dec_rs2  in  5 each  decode source register indices.
REQ-007 i_dec_use_rs1, i_dec_use_rs2  in  1 each  the decode instruction actually reads that source.
REQ-008 i_rr_valid, i_rr_rd, i_rr_is_load  in  1/5/1  register-read stage: valid, destination, is-load.
REQ-009 i_ex_valid, i_ex_rd  in  1/5  exec stage: valid, destination not yet written back.
REQ-010 i_ex_busy  in  1  exec is running a multi-cycle operation (level).
REQ-011 i_ld_new_pc  in  1  exec redirects the PC this cycle.
REQ-012 o_front_stall  out  1  fetch and decode hold their registers.
REQ-013 o_rr_stall  out  1  register-read holds its output register.
REQ-014 o_rr_bubble  out  1  register-read loads a NOP bubble instead of the decode instruction.
REQ-015 o_pipe_flush  out  1  fetch, decode and register-read invalidate their contents.
REQ-016 o_stall_count  out  CNT_W  count of cycles with o_front_stall=1.

Function
REQ-017 FSM states SHALL be RUN, MC_WAIT and FLUSH; the reset state is RUN.
REQ-018 Event priority SHALL be: redirect > multi-cycle busy > data hazard.
REQ-019 A register match SHALL count only if the index is nonzero, the producer stage is valid, i_dec_valid=1 and the matching use bit is 1.
REQ-020 Hazard (RUN, no busy, no redirect): o_front_stall=1 and o_rr_bubble=1 in the same cycle (combinational), o_rr_stall=0; the condition clears naturally once the producer moves on.
REQ-021 i_ld_new_pc=1 in any state: o_pipe_flush=1 in that same cycle with all stall and bubble outputs 0; the FSM enters FLUSH with the counter = FLUSH_CYCLES-1, or stays in RUN if FLUSH_CYCLES=1.
REQ-022 FLUSH: o_pipe_flush=1 with stalls and bubble 0; the counter decrements each cycle and the FSM returns to RUN on the cycle after it reaches 0.
REQ-023 A new i_ld_new_pc during FLUSH SHALL reload the counter to FLUSH_CYCLES-1.
REQ-024 i_ex_busy=1 (RUN, no redirect): o_front_stall=1, o_rr_stall=1 and o_rr_bubble=0 combinationally, and the FSM enters MC_WAIT.
REQ-025 MC_WAIT: o_front_stall and o_rr_stall stay high while i_ex_busy=1; on the first cycle with i_ex_busy=0 the FSM returns to RUN and hazard logic re-evaluates in that same cycle.
REQ-026 o_stall_count SHALL increment by 1 per cycle with o_front_stall=1 and saturate at all-ones.
REQ-027 o_front_stall, o_rr_stall and o_rr_bubble SHALL never be asserted together with o_pipe_flush.

Reset
REQ-028 Asserting i_reset at any time, including mid-FLUSH or mid-MC_WAIT, SHALL immediately force state RUN, flush counter 0 and o_stall_count 0.
REQ-029 While i_reset=1, o_pipe_flush, o_front_stall, o_rr_stall and o_rr_bubble SHALL all be 0.

Configuration
REQ-030 Macro TINY_RV_PIPE_CTRL_FWD_EN defined: RR-to-decode and EX-to-decode values are forwarded, so a hazard exists only on an RR-stage match with i_rr_is_load=1.
REQ-031 TINY_RV_PIPE_CTRL_FWD_EN undefined: a hazard exists on any RR-stage or EX-stage destination match, regardless of i_rr_is_load.

Structure
REQ-032 The shared package tiny_rv_pkg SHALL hold the pipe_ctrl_state_t enum, the OP_LOAD opcode constant and the REG_ZERO constant.
REQ-033 Register-match logic SHALL live in the combinational sub-module tiny_rv_hazard_detect; the FSM, flush counter and stall counter stay in tiny_rv_pipe_ctrl.

Verification
REQ-034 FWD_EN defined; RR is load with rd=5, decode rs1=5 with use_rs1=1 -> front_stall=1 and rr_bubble=1 for exactly 1 cycle; stall_count=1.
REQ-035 FWD_EN undefined; EX rd=7, decode rs2=7 with use_rs2=1 -> hazard asserted; the same pattern with rd=0 -> no stall.
REQ-036 FLUSH_CYCLES=2; i_ld_new_pc pulsed 1 cycle -> o_pipe_flush high exactly 2 cycles; a second pulse on the second cycle -> flush extends to 3 cycles in total.
REQ-037 i_ex_busy high 4 cycles while a load-use hazard is present -> front_stall and rr_stall high 4 cycles with rr_bubble 0, then 1 bubble cycle; stall_count=5.
REQ-038 i_ld_new_pc together with i_ex_busy and a hazard in the same cycle -> only o_pipe_flush=1.
REQ-039 i_reset asserted mid-FLUSH -> all outputs 0 immediately; after release, state is RUN and stall_count=0.

Source files
------------

// File: rtl/tiny_rv_pkg.sv
// Shared types and constants for the tiny RV pipeline control slice.
// Consumers: tiny_rv_hazard_detect, tiny_rv_pipe_ctrl.
package tiny_rv_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } pipe_ctrl_state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/tiny_rv_hazard_detect.sv
// Combinational source/destination match between decode and the RR/EX producers.
// Macro TINY_RV_PIPE_CTRL_FWD_EN: with forwarding only an RR-stage load is a hazard.
module tiny_rv_hazard_detect
    import tiny_rv_pkg::*;
(
    input  logic       dec_valid,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    input  logic       dec_use_rs1,
    input  logic       dec_use_rs2,
    input  logic       rr_valid,
    input  logic [4:0] rr_rd,
    input  logic       rr_is_load,
    input  logic       ex_valid,
    input  logic [4:0] ex_rd,
    output logic       hazard
);

    logic rr_match;
    logic ex_match;

    assign rr_match = dec_valid && rr_valid &&
                      ((dec_use_rs1 && (dec_rs1 != REG_ZERO) && (dec_rs1 == rr_rd)) ||
                       (dec_use_rs2 && (dec_rs2 != REG_ZERO) && (dec_rs2 == rr_rd)));

    assign ex_match = dec_valid && ex_valid &&
                      ((dec_use_rs1 && (dec_rs1 != REG_ZERO) && (dec_rs1 == ex_rd)) ||
                       (dec_use_rs2 && (dec_rs2 != REG_ZERO) && (dec_rs2 == ex_rd)));

`ifdef TINY_RV_PIPE_CTRL_FWD_EN
    // EX results are always forwardable, so only a load still in RR can stall.
    logic unused_ex_match;
    assign unused_ex_match = ex_match;
    assign hazard = rr_match && rr_is_load;
`else
    logic unused_rr_is_load;
    assign unused_rr_is_load = rr_is_load;
    assign hazard = rr_match || ex_match;
`endif

endmodule

// File: rtl/tiny_rv_pipe_ctrl.sv
// Pipeline stall/bubble/flush controller: redirect > multi-cycle busy > data hazard.
// Hazard rules depend on macro TINY_RV_PIPE_CTRL_FWD_EN (see tiny_rv_hazard_detect).
//
// state      | meaning
// ST_RUN     | normal issue; hazards stall front end and bubble RR
// ST_MC_WAIT | exec busy with a multi-cycle op; front end and RR held
// ST_FLUSH   | redirect in progress; front stages invalidated
module tiny_rv_pipe_ctrl
    import tiny_rv_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_dec_valid,
    input  logic [4:0]       i_dec_rs1,
    input  logic [4:0]       i_dec_rs2,
    input  logic             i_dec_use_rs1,
    input  logic             i_dec_use_rs2,
    input  logic             i_rr_valid,
    input  logic [4:0]       i_rr_rd,
    input  logic             i_rr_is_load,
    input  logic             i_ex_valid,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_busy,
    input  logic             i_ld_new_pc,
    output logic             o_front_stall,
    output logic             o_rr_stall,
    output logic             o_rr_bubble,
    output logic             o_pipe_flush,
    output logic [CNT_W-1:0] o_stall_count
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    pipe_ctrl_state_t state;
    logic [2:0]       flush_cnt;
    logic             hazard;

    tiny_rv_hazard_detect u_hazard (
        .dec_valid   (i_dec_valid),
        .dec_rs1     (i_dec_rs1),
        .dec_rs2     (i_dec_rs2),
        .dec_use_rs1 (i_dec_use_rs1),
        .dec_use_rs2 (i_dec_use_rs2),
        .rr_valid    (i_rr_valid),
        .rr_rd       (i_rr_rd),
        .rr_is_load  (i_rr_is_load),
        .ex_valid    (i_ex_valid),
        .ex_rd       (i_ex_rd),
        .hazard      (hazard)
    );

    // Outputs are combinational so a redirect or hazard acts in the cycle it appears.
    always_comb begin
        o_front_stall = 1'b0;
        o_rr_stall    = 1'b0;
        o_rr_bubble   = 1'b0;
        o_pipe_flush  = 1'b0;
        if (!i_reset) begin
            if (i_ld_new_pc || state == ST_FLUSH) begin
                o_pipe_flush = 1'b1;
            end else if (i_ex_busy) begin
                o_front_stall = 1'b1;
                o_rr_stall    = 1'b1;
            end else if (hazard) begin
                o_front_stall = 1'b1;
                o_rr_bubble   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= ST_RUN;
            flush_cnt     <= 3'd0;
            o_stall_count <= '0;
        end else begin
            if (o_front_stall && (o_stall_count != {CNT_W{1'b1}})) begin
                o_stall_count <= o_stall_count + CNT_W'(1);
            end
            if (i_ld_new_pc) begin
                flush_cnt <= FLUSH_RELOAD;
                state     <= (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (i_ex_busy) state <= ST_MC_WAIT;
                    end
                    ST_MC_WAIT: begin
                        if (!i_ex_busy) state <= ST_RUN;
                    end
                    ST_FLUSH: begin
                        // Counter hitting 0 here means the next cycle is back in RUN.
                        if (flush_cnt <= 3'd1) begin
                            flush_cnt <= 3'd0;
                            state     <= ST_RUN;
                        end else begin
                            flush_cnt <= flush_cnt - 3'd1;
                        end
                    end
                    default: state <= ST_RUN;
                endcase
            end
        end
    end

endmodule
